// File: rtl/clock_register.sv
// rtl/clock_register.sv - BCD time-of-day register with button set mode
// Optional 12-hour mode with o_pm output when CLOCK_12HR_EN is defined.
module clock_register #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena_1hz,
  input  logic       ena_set,
  input  logic       i_fast_set,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic [7:0] o_hours,
  output logic [7:0] o_minutes,
  output logic [7:0] o_seconds,
`ifdef CLOCK_12HR_EN
  output logic       o_pm,
`endif
  output logic       o_setting
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

`ifdef CLOCK_12HR_EN
  localparam logic [7:0] HOURS_INIT = 8'h12;
`else
  localparam logic [7:0] HOURS_INIT = 8'h00;
`endif

  state_t state, next_state;
  logic [SYNC_STAGES-1:0] sync_hours, sync_minutes, sync_fast;
  logic set_hours, set_minutes, fast_set, strobe;
  logic [7:0] hours, minutes, seconds;
  logic pm;

  // Seconds and minutes share the same 00..59 BCD counter.
  function automatic logic [7:0] inc_sixty(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      inc_sixty = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else
      inc_sixty = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hours(input logic [7:0] v);
`ifdef CLOCK_12HR_EN
    if (v == 8'h12)
      inc_hours = 8'h01;
    else if (v == 8'h11)
      inc_hours = 8'h12;
`else
    if (v == 8'h23)
      inc_hours = 8'h00;
`endif
    else if (v[3:0] == 4'd9)
      inc_hours = {v[7:4] + 4'd1, 4'd0};
    else
      inc_hours = {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_hours   <= '0;
      sync_minutes <= '0;
      sync_fast    <= '0;
    end else begin
      sync_hours   <= {sync_hours[SYNC_STAGES-2:0], i_set_hours};
      sync_minutes <= {sync_minutes[SYNC_STAGES-2:0], i_set_minutes};
      sync_fast    <= {sync_fast[SYNC_STAGES-2:0], i_fast_set};
    end
  end

  assign set_hours   = sync_hours[SYNC_STAGES-1];
  assign set_minutes = sync_minutes[SYNC_STAGES-1];
  assign fast_set    = sync_fast[SYNC_STAGES-1];

  always_comb begin
    next_state = state;
    strobe     = fast_set ? ena_set : ena_1hz;
    case (state)
      RUN: if (set_hours || set_minutes) next_state = SET;
      SET: if (!set_hours && !set_minutes) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      hours   <= HOURS_INIT;
      minutes <= 8'h00;
      seconds <= 8'h00;
      pm      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == RUN) begin
        // Entry edge only clears seconds; time does not also tick here.
        if (next_state == SET) begin
          seconds <= 8'h00;
        end else if (ena_1hz) begin
          seconds <= inc_sixty(seconds);
          if (seconds == 8'h59) begin
            minutes <= inc_sixty(minutes);
            if (minutes == 8'h59) begin
              hours <= inc_hours(hours);
              if (hours == 8'h11) pm <= ~pm;
            end
          end
        end
      end else begin
        seconds <= 8'h00;
        if (strobe) begin
          if (set_minutes) minutes <= inc_sixty(minutes);
          if (set_hours) begin
            hours <= inc_hours(hours);
            if (hours == 8'h11) pm <= ~pm;
          end
        end
      end
    end
  end

  assign o_hours   = hours;
  assign o_minutes = minutes;
  assign o_seconds = seconds;
  assign o_setting = (state == SET);

`ifdef CLOCK_12HR_EN
  assign o_pm = pm;
`else
  logic unused_pm;
  assign unused_pm = pm;
`endif

endmodule

// File: tb/tb_clock_register.sv
// tb/tb_clock_register.sv - directed self-checking bench for clock_register
// Runs the 12-hour sequence instead when CLOCK_12HR_EN is defined.
module tb_clock_register;

  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ena_1hz = 1'b0;
  logic ena_set = 1'b0;
  logic i_fast_set = 1'b0;
  logic i_set_hours = 1'b0;
  logic i_set_minutes = 1'b0;
  logic [7:0] o_hours, o_minutes, o_seconds;
  logic o_setting;
`ifdef CLOCK_12HR_EN
  logic o_pm;
`endif

  int tests = 0;
  int fails = 0;
  int bad = 0;

  clock_register #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .ena_1hz(ena_1hz), .ena_set(ena_set),
    .i_fast_set(i_fast_set), .i_set_hours(i_set_hours), .i_set_minutes(i_set_minutes),
    .o_hours(o_hours), .o_minutes(o_minutes), .o_seconds(o_seconds),
`ifdef CLOCK_12HR_EN
    .o_pm(o_pm),
`endif
    .o_setting(o_setting)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic p1(input int n);
    repeat (n) begin
      ena_1hz = 1'b1;
      cyc(1);
      ena_1hz = 1'b0;
    end
  endtask

  task automatic ps(input int n);
    repeat (n) begin
      ena_set = 1'b1;
      cyc(1);
      ena_set = 1'b0;
    end
  endtask

  function automatic bit sixty_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic bit time_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
`ifdef CLOCK_12HR_EN
    bit hok = (h >= 8'h01 && h <= 8'h09) || h == 8'h10 || h == 8'h11 || h == 8'h12;
`else
    bit hok = (h[3:0] <= 4'd9) && (h <= 8'h23);
`endif
    return hok && sixty_ok(m) && sixty_ok(s);
  endfunction

  initial begin
`ifndef CLOCK_12HR_EN
    cyc(2);
    check("reset_hours", o_hours, 8'h00);
    check("reset_minutes", o_minutes, 8'h00);
    check("reset_seconds", o_seconds, 8'h00);
    check("reset_setting", o_setting, 1'b0);
    reset = 1'b0;

    p1(59);
    check("s59_seconds", o_seconds, 8'h59);
    check("s59_minutes", o_minutes, 8'h00);
    p1(1);
    check("m01_seconds", o_seconds, 8'h00);
    check("m01_minutes", o_minutes, 8'h01);

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    ena_1hz = 1'b1;
    for (int i = 1; i <= 86400; i++) begin
      cyc(1);
      if (!time_ok(o_hours, o_minutes, o_seconds)) bad++;
      if (i == 86399) begin
        check("eod_hours", o_hours, 8'h23);
        check("eod_minutes", o_minutes, 8'h59);
        check("eod_seconds", o_seconds, 8'h59);
      end
    end
    ena_1hz = 1'b0;
    check("wrap_hours", o_hours, 8'h00);
    check("wrap_minutes", o_minutes, 8'h00);
    check("wrap_seconds", o_seconds, 8'h00);
    check("day_invalid_samples", bad, 0);

    i_fast_set = 1'b1;
    i_set_hours = 1'b1;
    cyc(S + 1);
    check("set_enter", o_setting, 1'b1);
    ps(10);
    check("set_hours10", o_hours, 8'h10);
    i_set_hours = 1'b0;
    i_set_minutes = 1'b1;
    cyc(S + 1);
    ps(20);
    i_set_minutes = 1'b0;
    cyc(S + 1);
    check("set_leave", o_setting, 1'b0);
    p1(35);
    check("t1_hours", o_hours, 8'h10);
    check("t1_minutes", o_minutes, 8'h20);
    check("t1_seconds", o_seconds, 8'h35);

    i_set_minutes = 1'b1;
    cyc(S + 1);
    check("entry_setting", o_setting, 1'b1);
    check("entry_seconds", o_seconds, 8'h00);
    ps(45);
    check("fast_minutes", o_minutes, 8'h05);
    check("fast_hours", o_hours, 8'h10);
    check("fast_seconds", o_seconds, 8'h00);
    check("fast_setting", o_setting, 1'b1);
    i_set_minutes = 1'b0;
    cyc(S + 1);
    check("release_setting", o_setting, 1'b0);
    p1(1);
    check("resume_hours", o_hours, 8'h10);
    check("resume_minutes", o_minutes, 8'h05);
    check("resume_seconds", o_seconds, 8'h01);

    i_fast_set = 1'b0;
    i_set_hours = 1'b1;
    i_set_minutes = 1'b1;
    cyc(S + 1);
    check("both_seconds", o_seconds, 8'h00);
    p1(1);
    ps(4);
    ena_1hz = 1'b1;
    ena_set = 1'b1;
    cyc(1);
    ena_1hz = 1'b0;
    ena_set = 1'b0;
    check("coinc_hours", o_hours, 8'h12);
    check("coinc_minutes", o_minutes, 8'h07);
    p1(1);
    check("both_hours", o_hours, 8'h13);
    check("both_minutes", o_minutes, 8'h08);
    check("both_seconds_held", o_seconds, 8'h00);

    i_set_hours = 1'b0;
    i_set_minutes = 1'b0;
    cyc(S + 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    i_fast_set = 1'b1;
    i_set_hours = 1'b1;
    cyc(S + 1);
    ps(7);
    i_set_hours = 1'b0;
    i_set_minutes = 1'b1;
    cyc(S + 1);
    ps(33);
    check("pre_rst_hours", o_hours, 8'h07);
    check("pre_rst_minutes", o_minutes, 8'h33);
    check("pre_rst_setting", o_setting, 1'b1);
    reset = 1'b1;
    cyc(1);
    check("abort_hours", o_hours, 8'h00);
    check("abort_minutes", o_minutes, 8'h00);
    check("abort_seconds", o_seconds, 8'h00);
    check("abort_setting", o_setting, 1'b0);
    reset = 1'b0;
    cyc(S);
    check("resync_low", o_setting, 1'b0);
    cyc(1);
    check("resync_high", o_setting, 1'b1);
`else
    cyc(2);
    check("reset_hours", o_hours, 8'h12);
    check("reset_minutes", o_minutes, 8'h00);
    check("reset_seconds", o_seconds, 8'h00);
    check("reset_pm", o_pm, 1'b0);
    check("reset_setting", o_setting, 1'b0);
    reset = 1'b0;

    ena_1hz = 1'b1;
    for (int i = 1; i <= 43200; i++) begin
      cyc(1);
      if (!time_ok(o_hours, o_minutes, o_seconds)) bad++;
      if (i == 43199) begin
        check("am_end_hours", o_hours, 8'h11);
        check("am_end_minutes", o_minutes, 8'h59);
        check("am_end_seconds", o_seconds, 8'h59);
        check("am_end_pm", o_pm, 1'b0);
      end
    end
    ena_1hz = 1'b0;
    check("noon_hours", o_hours, 8'h12);
    check("noon_minutes", o_minutes, 8'h00);
    check("noon_seconds", o_seconds, 8'h00);
    check("noon_pm", o_pm, 1'b1);
    check("half_invalid_samples", bad, 0);

    p1(3599);
    check("h12_end_hours", o_hours, 8'h12);
    check("h12_end_seconds", o_seconds, 8'h59);
    p1(1);
    check("one_hours", o_hours, 8'h01);
    check("one_minutes", o_minutes, 8'h00);
    check("one_pm", o_pm, 1'b1);

    i_fast_set = 1'b1;
    i_set_hours = 1'b1;
    cyc(S + 1);
    check("set_enter", o_setting, 1'b1);
    ps(10);
    check("set_hours11", o_hours, 8'h11);
    check("set_pm_held", o_pm, 1'b1);
    ps(1);
    check("set_hours12", o_hours, 8'h12);
    check("set_pm_toggle", o_pm, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_register.md
Name: clock_register

Overview:
- Time-of-day register that sits directly downstream of the clock divider.
- Consumes the divider's 1 Hz tick and set-rate tick as single-cycle enables on the system clock.
- Keeps hours/minutes/seconds in packed BCD and handles hour/minute setting from the front-panel buttons.
- BCD outputs feed the display shift-register stage.

Parameters:
- SYNC_STAGES, 2, depth of the button synchronizer flops (min 2).

Ports:
- clk  input  1  system clock (12.5 kHz nominal)
- reset  input  1  synchronous, active-high reset
- ena_1hz  input  1  one-cycle pulse, once per second, from clock divider
- ena_set  input  1  one-cycle pulse at fast-set rate, from clock divider
- i_fast_set  input  1  button: select fast set rate (async, debounced externally)
- i_set_hours  input  1  button: advance hours (async, debounced externally)
- i_set_minutes  input  1  button: advance minutes (async, debounced externally)
- o_hours  output  8  BCD {tens[7:4], ones[3:0]}, tens 0-2
- o_minutes  output  8  BCD {tens[7:4], ones[3:0]}, tens 0-5
- o_seconds  output  8  BCD {tens[7:4], ones[3:0]}, tens 0-5
- o_setting  output  1  high while in SET state

Behaviour:
- Reset:
  - Synchronous, active-high; sampled on rising clk and dominates everything else.
  - Outputs 00:00:00 (0x00 on all three), o_setting=0, state RUN, synchronizer flops 0.
  - Reset asserted mid-set aborts the set; the time is lost.
- Buttons:
  - Each button passes through SYNC_STAGES flops.
  - The FSM sees a button SYNC_STAGES cycles after it changes; all later references mean the synchronized versions.
- FSM states: RUN, SET.
  - RUN -> SET when set_hours or set_minutes is high.
  - SET -> RUN when both are low.
  - i_fast_set alone does not change state.
- RUN:
  - On ena_1hz, seconds increment and all fields update in the same clock edge.
  - Roll-overs: seconds ones 9->0 with carry to tens; tens 5 with ones 9 -> 00 and carry to minutes.
  - Minutes roll 59->00 with carry to hours.
  - Hours roll 23->00 (ones 9->0 with carry to tens; 23->00).
  - 23:59:59 + tick -> 00:00:00 in one edge.
  - ena_set is ignored in RUN.
- SET:
  - Seconds are forced to 00 on entry and held at 00; ena_1hz does not advance time.
  - Advance strobe = ena_set if fast_set is high, else ena_1hz.
  - On each strobe, hours increment if set_hours is high (23->00, no carry anywhere).
  - On each strobe, minutes increment if set_minutes is high (59->00, no carry into hours).
  - Both buttons held: both fields advance on the same strobe.
  - o_setting=1.
- SET -> RUN: seconds remain 00; the next ena_1hz yields :01.
- Simultaneous pulses: ena_1hz and ena_set in the same cycle give at most one increment per field per cycle.
- Latency: outputs are registered, so a field changes on the clk edge where the enable is sampled high.
- Invariant: outputs never hold a non-BCD or out-of-range value. An out-of-range value can only arise from an implementation bug; it is a checker failure.

Optional Feature:
- Macro: CLOCK_12HR_EN.
- Defined:
  - Hours count 12-hour style, 12,01..11, and an extra output o_pm (1 bit) is added.
  - Reset value 12:00:00 with o_pm=0.
  - In RUN, 11:59:59 -> 12:00:00 toggles o_pm; 12:59:59 -> 01:00:00 leaves o_pm unchanged.
  - In SET, hour advance 11->12 toggles o_pm, so setting cycles through the full day.
- Undefined: 24-hour behaviour as above; port o_pm is absent.

Test Plan:
- Reset, then 59 ena_1hz pulses -> o_seconds=0x59, o_minutes=0x00; one more pulse -> 0x00/0x01.
- Force-count from reset through 86400 ena_1hz pulses -> outputs pass 23:59:59 and return to 00:00:00 exactly on pulse 86400; every sample is valid BCD.
- Run to 10:20:35, hold i_set_minutes with i_fast_set=1 and issue 45 ena_set pulses -> o_minutes=0x05, o_hours=0x10, o_seconds=0x00, o_setting=1. Release, wait SYNC_STAGES+1 cycles -> o_setting=0; next ena_1hz gives 10:05:01.
- Hold both set buttons with i_fast_set=0 and issue 3 ena_1hz pulses plus 5 ena_set pulses (ena_set ignored) -> hours and minutes each +3; pulses coinciding in one cycle give a single increment.
- Assert reset mid-SET at 07:33:00 -> next edge 00:00:00, o_setting=0, state RUN while the button is still held. The FSM re-enters SET only after the synchronizer latency.
- With CLOCK_12HR_EN defined: from reset apply 43200 ena_1hz pulses -> 12:00:00 with o_pm=1. Check the 12:59:59 -> 01:00:00 transition keeps o_pm unchanged.
